// File: rtl/chu_blk_serializer_if.sv
// rtl/chu_blk_serializer_if.sv - block input handshake and word-stream output bundle
interface chu_blk_serializer_if #(
  parameter int WORDS = 16,
  parameter int DW    = 32,
  parameter int CW    = 8
);
  logic                  blk_val;
  logic                  blk_rdy;
  logic [WORDS*DW-1:0]   blk_w;
  logic [WORDS-1:0]      blk_w_val;
  logic                  blk_last;
  logic [2:0]            blk_alg;
  logic [DW-1:0]         data;
  logic                  val;
  logic                  sop;
  logic                  eop;
  logic [2:0]            alg;
  logic [CW-1:0]         mes_cnt;
  logic                  busy;

  modport master (
    output blk_val, blk_w, blk_w_val, blk_last, blk_alg,
    input  blk_rdy, data, val, sop, eop, alg, mes_cnt, busy
  );

  modport slave (
    input  blk_val, blk_w, blk_w_val, blk_last, blk_alg,
    output blk_rdy, data, val, sop, eop, alg, mes_cnt, busy
  );
endinterface

// File: rtl/chu_blk_serializer.sv
// rtl/chu_blk_serializer.sv - re-streams masked 16-word blocks as framed 32-bit words
module chu_blk_serializer #(
  parameter int WORDS = 16,
  parameter int DW    = 32,
  parameter int CW    = 8
) (
  input logic               sys_clk,
  input logic               sys_rst,
  chu_blk_serializer_if.slave bus
);
  localparam int IW = $clog2(WORDS);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              state_q, state_d;
  logic [WORDS*DW-1:0] w_q, w_d;
  logic [WORDS-1:0]    mask_q, mask_d;
  logic                last_q, last_d;
  logic [2:0]          balg_q, balg_d;
  logic [2:0]          alg_q, alg_d;
  logic                open_q, open_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [WORDS-1:0]    rem;
  logic [IW-1:0]       idx;
  logic                emit, final_word, rdy, accept, sop_w, eop_w;

  always_comb begin
    idx = '0;
    // Descending scan so the lowest set bit wins.
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (mask_q[i]) idx = i[IW-1:0];
    end
    rem      = mask_q;
    rem[idx] = 1'b0;

    emit       = (state_q == S_SEND);
    final_word = emit && (rem == '0);
    rdy        = !sys_rst && ((state_q == S_IDLE) || final_word);
    accept     = bus.blk_val && rdy;
    sop_w      = emit && !open_q;
    eop_w      = final_word && last_q;

    state_d = state_q;
    w_d     = w_q;
    mask_d  = mask_q;
    last_d  = last_q;
    balg_d  = balg_q;
    alg_d   = alg_q;
    open_d  = open_q;
    cnt_d   = cnt_q;

    if (emit) begin
      mask_d = rem;
      open_d = !eop_w;
      if (sop_w) alg_d = balg_q;
      if (eop_w) cnt_d = cnt_q + 1'b1;
    end
    if (final_word) state_d = S_IDLE;

    // An all-zero mask is consumed but never reaches the stream.
    if (accept && (bus.blk_w_val != '0)) begin
      state_d = S_SEND;
      w_d     = bus.blk_w;
      mask_d  = bus.blk_w_val;
      last_d  = bus.blk_last;
      balg_d  = bus.blk_alg;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      balg_q  <= '0;
      alg_q   <= '0;
      open_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      balg_q  <= balg_d;
      alg_q   <= alg_d;
      open_q  <= open_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.blk_rdy = rdy;
  assign bus.val     = emit;
  assign bus.data    = emit ? w_q[idx*DW +: DW] : '0;
  assign bus.sop     = sop_w;
  assign bus.eop     = eop_w;
  assign bus.alg     = sop_w ? balg_q : alg_q;
  assign bus.mes_cnt = cnt_q;
  assign bus.busy    = emit;
endmodule

// File: tb/tb_chu_blk_serializer.sv
// tb/tb_chu_blk_serializer.sv - directed self-checking bench for chu_blk_serializer
module tb_chu_blk_serializer;
  localparam int WORDS = 16;
  localparam int DW    = 32;
  localparam int CW    = 8;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   total = 0;
  int   bad   = 0;

  chu_blk_serializer_if #(.WORDS(WORDS), .DW(DW), .CW(CW)) bus ();

  chu_blk_serializer #(.WORDS(WORDS), .DW(DW), .CW(CW)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [WORDS*DW-1:0] mk_words(input logic [31:0] base);
    logic [WORDS*DW-1:0] w;
    for (int i = 0; i < WORDS; i++) w[i*DW +: DW] = base + 32'(i);
    return w;
  endfunction

  task automatic offer(input logic [WORDS*DW-1:0] w, input logic [15:0] m,
                       input logic last, input logic [2:0] a);
    bus.blk_val   = 1'b1;
    bus.blk_w     = w;
    bus.blk_w_val = m;
    bus.blk_last  = last;
    bus.blk_alg   = a;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    total++;
    if (bus.blk_rdy !== 1'b0) begin
      bad++; $display("FAIL reset_rdy got=%b exp=0", bus.blk_rdy);
    end
    @(negedge sys_clk);
    total++;
    if ({bus.val, bus.sop, bus.eop, bus.busy, bus.data, bus.alg, bus.mes_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs val=%b sop=%b eop=%b busy=%b data=%h alg=%0d cnt=%0d exp all 0",
                      bus.val, bus.sop, bus.eop, bus.busy, bus.data, bus.alg, bus.mes_cnt);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    total++;
    if (bus.blk_rdy !== 1'b1) begin
      bad++; $display("FAIL reset_rdy_after got=%b exp=1", bus.blk_rdy);
    end
  endtask

  task automatic test_full_block();
    @(negedge sys_clk);
    offer(mk_words(32'h100), 16'hFFFF, 1'b1, 3'd3);
    @(posedge sys_clk); #1 bus.blk_val = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge sys_clk);
      total++;
      if ({bus.val, bus.sop, bus.eop, bus.busy} !== {1'b1, k == 0, k == 15, 1'b1}) begin
        bad++; $display("FAIL full_flags k=%0d val/sop/eop/busy=%b%b%b%b exp=1%b%b1",
                        k, bus.val, bus.sop, bus.eop, bus.busy, k == 0, k == 15);
      end
      total++;
      if (bus.data !== 32'h100 + 32'(k) || bus.alg !== 3'd3 || bus.mes_cnt !== 8'd0) begin
        bad++; $display("FAIL full_data k=%0d data=%h alg=%0d cnt=%0d exp data=%h alg=3 cnt=0",
                        k, bus.data, bus.alg, bus.mes_cnt, 32'h100 + 32'(k));
      end
    end
    @(negedge sys_clk);
    total++;
    if (bus.val !== 1'b0 || bus.mes_cnt !== 8'd1 || bus.data !== 32'h0) begin
      bad++; $display("FAIL full_after val=%b cnt=%0d data=%h exp val=0 cnt=1 data=0",
                      bus.val, bus.mes_cnt, bus.data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    @(negedge sys_clk);
    offer(mk_words(32'h200), 16'hFFFF, 1'b0, 3'd2);
    @(posedge sys_clk); #1 offer(mk_words(32'h400), 16'h00FF, 1'b1, 3'd5);
    for (int k = 0; k < 24; k++) begin
      @(negedge sys_clk);
      exp_d = (k < 16) ? 32'h200 + 32'(k) : 32'h400 + 32'(k - 16);
      total++;
      if ({bus.val, bus.sop, bus.eop, bus.blk_rdy} !== {1'b1, k == 0, k == 23, (k == 15) || (k == 23)}) begin
        bad++; $display("FAIL b2b_flags k=%0d val/sop/eop/rdy=%b%b%b%b exp=1%b%b%b",
                        k, bus.val, bus.sop, bus.eop, bus.blk_rdy, k == 0, k == 23, (k == 15) || (k == 23));
      end
      total++;
      if (bus.data !== exp_d || bus.alg !== 3'd2 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL b2b_data k=%0d data=%h alg=%0d busy=%b exp data=%h alg=2 busy=1",
                        k, bus.data, bus.alg, bus.busy, exp_d);
      end
      if (k == 15) begin
        @(posedge sys_clk); #1 bus.blk_val = 1'b0;
      end
    end
    @(negedge sys_clk);
    total++;
    if (bus.val !== 1'b0 || bus.mes_cnt !== 8'd2) begin
      bad++; $display("FAIL b2b_after val=%b cnt=%0d exp val=0 cnt=2", bus.val, bus.mes_cnt);
    end
  endtask

  task automatic test_sparse();
    @(negedge sys_clk);
    offer(mk_words(32'h300), 16'h8001, 1'b1, 3'd1);
    @(posedge sys_clk); #1 bus.blk_val = 1'b0;
    @(negedge sys_clk);
    total++;
    if ({bus.val, bus.sop, bus.eop} !== 3'b110 || bus.data !== 32'h300 || bus.alg !== 3'd1) begin
      bad++; $display("FAIL sparse_w0 vse=%b%b%b data=%h alg=%0d exp vse=110 data=300 alg=1",
                      bus.val, bus.sop, bus.eop, bus.data, bus.alg);
    end
    @(negedge sys_clk);
    total++;
    if ({bus.val, bus.sop, bus.eop} !== 3'b101 || bus.data !== 32'h30F) begin
      bad++; $display("FAIL sparse_w15 vse=%b%b%b data=%h exp vse=101 data=30f",
                      bus.val, bus.sop, bus.eop, bus.data);
    end
    @(negedge sys_clk);
    total++;
    if (bus.val !== 1'b0 || bus.mes_cnt !== 8'd3) begin
      bad++; $display("FAIL sparse_after val=%b cnt=%0d exp val=0 cnt=3", bus.val, bus.mes_cnt);
    end
  endtask

  task automatic test_empty();
    @(negedge sys_clk);
    offer(mk_words(32'h900), 16'h0000, 1'b1, 3'd7);
    @(posedge sys_clk); #1 bus.blk_val = 1'b0;
    @(negedge sys_clk);
    total++;
    if ({bus.val, bus.blk_rdy, bus.busy} !== 3'b010 || bus.mes_cnt !== 8'd3 || bus.alg !== 3'd1) begin
      bad++; $display("FAIL empty_state val/rdy/busy=%b%b%b cnt=%0d alg=%0d exp 010 cnt=3 alg=1",
                      bus.val, bus.blk_rdy, bus.busy, bus.mes_cnt, bus.alg);
    end
    offer(mk_words(32'h500), 16'h0004, 1'b1, 3'd4);
    @(posedge sys_clk); #1 bus.blk_val = 1'b0;
    @(negedge sys_clk);
    total++;
    if ({bus.val, bus.sop, bus.eop} !== 3'b111 || bus.data !== 32'h502 || bus.alg !== 3'd4) begin
      bad++; $display("FAIL empty_next vse=%b%b%b data=%h alg=%0d exp vse=111 data=502 alg=4",
                      bus.val, bus.sop, bus.eop, bus.data, bus.alg);
    end
    @(negedge sys_clk);
    total++;
    if (bus.mes_cnt !== 8'd4) begin
      bad++; $display("FAIL empty_cnt got=%0d exp=4", bus.mes_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge sys_clk);
    offer(mk_words(32'h600), 16'hFFFF, 1'b1, 3'd6);
    @(posedge sys_clk); #1 bus.blk_val = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      total++;
      if ({bus.val, bus.sop} !== {1'b1, k == 0} || bus.data !== 32'h600 + 32'(k)) begin
        bad++; $display("FAIL rmid_word k=%0d val=%b sop=%b data=%h exp val=1 sop=%b data=%h",
                        k, bus.val, bus.sop, bus.data, k == 0, 32'h600 + 32'(k));
      end
    end
    sys_rst = 1'b1;
    #1;
    total++;
    if (bus.blk_rdy !== 1'b0) begin
      bad++; $display("FAIL rmid_rdy_in_reset got=%b exp=0", bus.blk_rdy);
    end
    @(negedge sys_clk);
    total++;
    if ({bus.val, bus.sop, bus.eop, bus.busy, bus.blk_rdy} !== 5'b0 || bus.data !== 32'h0 || bus.mes_cnt !== 8'd0) begin
      bad++; $display("FAIL rmid_cleared vse/busy/rdy=%b%b%b%b%b data=%h cnt=%0d exp all 0",
                      bus.val, bus.sop, bus.eop, bus.busy, bus.blk_rdy, bus.data, bus.mes_cnt);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    total++;
    if (bus.blk_rdy !== 1'b1 || bus.val !== 1'b0) begin
      bad++; $display("FAIL rmid_idle rdy=%b val=%b exp rdy=1 val=0", bus.blk_rdy, bus.val);
    end
    offer(mk_words(32'h700), 16'h0003, 1'b1, 3'd2);
    @(posedge sys_clk); #1 bus.blk_val = 1'b0;
    @(negedge sys_clk);
    total++;
    if ({bus.val, bus.sop, bus.eop} !== 3'b110 || bus.data !== 32'h700 || bus.alg !== 3'd2) begin
      bad++; $display("FAIL rmid_new_sop vse=%b%b%b data=%h alg=%0d exp vse=110 data=700 alg=2",
                      bus.val, bus.sop, bus.eop, bus.data, bus.alg);
    end
    @(negedge sys_clk);
    total++;
    if ({bus.val, bus.sop, bus.eop} !== 3'b101 || bus.data !== 32'h701) begin
      bad++; $display("FAIL rmid_new_eop vse=%b%b%b data=%h exp vse=101 data=701",
                      bus.val, bus.sop, bus.eop, bus.data);
    end
    @(negedge sys_clk);
    total++;
    if (bus.mes_cnt !== 8'd1) begin
      bad++; $display("FAIL rmid_cnt got=%0d exp=1", bus.mes_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_c;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int j = 0; j < 256; j++) begin
      @(negedge sys_clk);
      offer(mk_words(32'h1000 + 32'(j)), 16'h0001, 1'b1, 3'(j));
      @(posedge sys_clk); #1 bus.blk_val = 1'b0;
      @(negedge sys_clk);
      total++;
      if ({bus.val, bus.sop, bus.eop} !== 3'b111 || bus.data !== 32'h1000 + 32'(j)) begin
        bad++; $display("FAIL wrap_word j=%0d vse=%b%b%b data=%h exp vse=111 data=%h",
                        j, bus.val, bus.sop, bus.eop, bus.data, 32'h1000 + 32'(j));
      end
      @(negedge sys_clk);
      exp_c = 8'(j + 1);
      total++;
      if (bus.mes_cnt !== exp_c) begin
        bad++; $display("FAIL wrap_cnt j=%0d got=%0d exp=%0d", j, bus.mes_cnt, exp_c);
      end
    end
  endtask

  initial begin
    sys_rst       = 1'b1;
    bus.blk_val   = 1'b0;
    bus.blk_w     = '0;
    bus.blk_w_val = '0;
    bus.blk_last  = 1'b0;
    bus.blk_alg   = '0;
    test_reset();
    test_full_block();
    test_back_to_back();
    test_sparse();
    test_empty();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
